// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target character transceiver.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

  // Encoded as {CPHA, CPOL}
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE2 = 2'b01,
    MODE1 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  localparam int unsigned CHAR_LEN_MIN = 3;
  localparam int unsigned CHAR_LEN_MAX = 15;

  // Keeps an out-of-range length inside both the protocol range and the data path width.
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int unsigned nbits);
    int unsigned top;
    int unsigned l;
    top = ((nbits - 1) < CHAR_LEN_MAX) ? (nbits - 1) : CHAR_LEN_MAX;
    l   = 32'(len);
    if (l < CHAR_LEN_MIN) return 4'(CHAR_LEN_MIN);
    if (l > top)          return 4'(top);
    return len;
  endfunction

  function automatic logic sample_on_rise(input spi_mode_e m);
    return (m == MODE0) || (m == MODE3);
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall event pulses.
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave_trx_char.sv
// SPI target single-character transceiver, all four CPOL/CPHA modes, 4..16-bit characters.
// Optional sticky error flags with macro SPI_SLAVE_ERR_EN.
module spi_slave_trx_char
  import spi_pkg::*;
#(
  parameter int unsigned CHAR_NBITS  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  S_SYSCLK,
  input  logic                  S_RESETN,
  input  logic                  S_ENABLE,
  input  logic                  S_CPOL,
  input  logic                  S_CPHA,
  input  logic                  S_REV,
  input  logic [3:0]            S_CHAR_LEN,
  input  logic                  S_SPI_SCK,
  input  logic                  S_SPI_CS_N,
  input  logic                  S_SPI_MOSI,
  output logic                  S_SPI_MISO,
  output logic                  S_SPI_MISO_OE,
  input  logic [CHAR_NBITS-1:0] S_WCHAR,
  input  logic                  S_WCHAR_VALID,
  output logic                  S_WCHAR_READY,
  output logic [CHAR_NBITS-1:0] S_RCHAR,
  output logic                  S_RCHAR_VALID,
  input  logic                  S_RCHAR_READY
`ifdef SPI_SLAVE_ERR_EN
  ,
  output logic                  S_OVERRUN,
  output logic                  S_UNDERRUN,
  input  logic                  S_ERR_CLR
`endif
);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk_i(S_SYSCLK), .rst_ni(S_RESETN), .async_i(S_SPI_SCK),
    .level_o(sck_level), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i(S_SYSCLK), .rst_ni(S_RESETN), .async_i(S_SPI_CS_N),
    .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(S_SYSCLK), .rst_ni(S_RESETN), .async_i(S_SPI_MOSI),
    .level_o(mosi_level), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_level, mosi_rise, mosi_fall};

  spi_state_e            state_q, state_d;
  spi_mode_e             mode_q, mode_d;
  logic                  rev_q, rev_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  done_q, done_d;
  logic [CHAR_NBITS-1:0] tx_sh_q, tx_sh_d;
  logic [CHAR_NBITS-1:0] rx_sh_q, rx_sh_d;
  logic                  miso_q, miso_d;
  logic                  oe_q, oe_d;
  logic [CHAR_NBITS-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [CHAR_NBITS-1:0] rchar_q, rchar_d;
  logic                  rvalid_q, rvalid_d;

  logic                  wr_ready;
  logic                  sample_ev, drive_ev;
  logic [CHAR_NBITS-1:0] tx_word;
  logic [3:0]            ld_len;

  assign wr_ready  = ~hold_full_q & (state_q != ST_LOAD);
  assign sample_ev = sample_on_rise(mode_q) ? sck_rise : sck_fall;
  assign drive_ev  = sample_on_rise(mode_q) ? sck_fall : sck_rise;
  assign ld_len    = clamp_len(S_CHAR_LEN, CHAR_NBITS);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    rev_d       = rev_q;
    len_d       = len_q;
    bit_cnt_d   = bit_cnt_q;
    done_d      = 1'b0;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rchar_d     = rchar_q;
    rvalid_d    = rvalid_q;
    tx_word     = hold_full_q ? hold_q : '1;

    if (wr_ready && S_WCHAR_VALID) begin
      hold_d      = S_WCHAR;
      hold_full_d = 1'b1;
    end
    if (rvalid_q && S_RCHAR_READY) rvalid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        oe_d      = 1'b0;
        bit_cnt_d = '0;
        if (S_ENABLE && cs_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        hold_full_d = 1'b0;
        mode_d      = spi_mode_e'({S_CPHA, S_CPOL});
        rev_d       = S_REV;
        len_d       = ld_len;
        bit_cnt_d   = '0;
        rx_sh_d     = '0;
        oe_d        = 1'b1;
        // CPHA=0 has no leading drive edge, so the first bit is presented right here.
        if (S_CPHA) begin
          tx_sh_d = tx_word;
        end else begin
          miso_d  = S_REV ? tx_word[ld_len] : tx_word[0];
          tx_sh_d = S_REV ? (tx_word << 1) : (tx_word >> 1);
        end
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (done_q) begin
          rchar_d   = rx_sh_q;
          rvalid_d  = 1'b1;
          bit_cnt_d = '0;
          if (cs_level) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
          end else begin
            state_d = ST_LOAD;
          end
        end else if (cs_rise) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end else if (sample_ev) begin
          if (rev_q) rx_sh_d[len_q - bit_cnt_q] = mosi_level;
          else       rx_sh_d[bit_cnt_q]         = mosi_level;
          if (bit_cnt_q == len_q) done_d    = 1'b1;
          else                    bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (drive_ev && (mode_q[1] || (bit_cnt_q != '0))) begin
          // CPHA=0: the drive edge trailing the last sample of a character belongs to the preload.
          miso_d  = rev_q ? tx_sh_q[len_q] : tx_sh_q[0];
          tx_sh_d = rev_q ? (tx_sh_q << 1) : (tx_sh_q >> 1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!S_ENABLE) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE0;
      rev_q       <= 1'b0;
      len_q       <= '0;
      bit_cnt_q   <= '0;
      done_q      <= 1'b0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rchar_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rev_q       <= rev_d;
      len_q       <= len_d;
      bit_cnt_q   <= bit_cnt_d;
      done_q      <= done_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rchar_q     <= rchar_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign S_SPI_MISO    = miso_q;
  assign S_SPI_MISO_OE = oe_q;
  assign S_WCHAR_READY = wr_ready;
  assign S_RCHAR       = rchar_q;
  assign S_RCHAR_VALID = rvalid_q;

`ifdef SPI_SLAVE_ERR_EN
  logic ovr_q, und_q;
  logic ovr_set, und_set;

  assign und_set = (state_q == ST_LOAD) && !hold_full_q;
  assign ovr_set = (state_q == ST_SHIFT) && done_q && rvalid_q && !S_RCHAR_READY;

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      ovr_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      ovr_q <= ovr_set | (ovr_q & ~S_ERR_CLR);
      und_q <= und_set | (und_q & ~S_ERR_CLR);
    end
  end

  assign S_OVERRUN  = ovr_q;
  assign S_UNDERRUN = und_q;
`endif

endmodule

// File: tb/tb_spi_slave_trx_char.sv
// Bench for spi_slave_trx_char: bit-level SPI master model plus expected words from masking rules.
`timescale 1ns/1ps
module tb_spi_slave_trx_char;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable, cpol, cpha, rev;
  logic [3:0]  char_len;
  logic        sck, cs_n, mosi, miso, miso_oe;
  logic [15:0] wchar;
  logic        wvalid, wready;
  logic [15:0] rchar;
  logic        rvalid, rready;
`ifdef SPI_SLAVE_ERR_EN
  logic        overrun, underrun, err_clr;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_slave_trx_char #(.CHAR_NBITS(16), .SYNC_STAGES(2)) dut (
    .S_SYSCLK(clk), .S_RESETN(rst_n), .S_ENABLE(enable),
    .S_CPOL(cpol), .S_CPHA(cpha), .S_REV(rev), .S_CHAR_LEN(char_len),
    .S_SPI_SCK(sck), .S_SPI_CS_N(cs_n), .S_SPI_MOSI(mosi),
    .S_SPI_MISO(miso), .S_SPI_MISO_OE(miso_oe),
    .S_WCHAR(wchar), .S_WCHAR_VALID(wvalid), .S_WCHAR_READY(wready),
    .S_RCHAR(rchar), .S_RCHAR_VALID(rvalid), .S_RCHAR_READY(rready)
`ifdef SPI_SLAVE_ERR_EN
    , .S_OVERRUN(overrun), .S_UNDERRUN(underrun), .S_ERR_CLR(err_clr)
`endif
  );

  // Receive monitor: consumed characters, valid rising edges, valid-high cycles.
  logic [15:0] rx_q[$];
  int          rv_events = 0;
  int          rv_high = 0;
  logic        rv_prev = 1'b0;
  always @(negedge clk) begin
    if (rvalid && rready) rx_q.push_back(rchar);
    if (rvalid && !rv_prev) rv_events++;
    if (rvalid) rv_high++;
    rv_prev = rvalid;
  end

  logic [15:0] mosi_w [4];
  logic [15:0] miso_w [4];
  logic [15:0] seq;

  function automatic logic [15:0] mask(input int len);
    return 16'((32'h1 << (len + 1)) - 1);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_hold(input logic [15:0] w);
    int t = 0;
    wchar  = w;
    wvalid = 1'b1;
    @(negedge clk);
    while (!wready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 wvalid = 1'b0;
    checks++;
    if (t >= 2000) begin
      failures++;
      $display("FAIL write_hold_timeout: wready=%0b after %0d cycles, required 1", wready, t);
    end
  endtask

  // One CS-low session of nchars characters; abort_bits>=0 stops after that many bits.
  task automatic session(input logic p, input logic h, input logic r, input int len,
                         input int nchars, input int abort_bits, input bit raise_cs);
    int   sent = 0;
    int   pos;
    logic b;
    cpol = p; cpha = h; rev = r; char_len = 4'(len); sck = p;
    seq = '0;
    wait_clk(6);
    cs_n = 1'b0;
    wait_clk(10);
    for (int c = 0; c < nchars; c++) begin
      miso_w[c] = '0;
      for (int i = 0; i <= len; i++) begin
        if (abort_bits >= 0 && sent == abort_bits) break;
        pos = r ? (len - i) : i;
        if (!h) begin
          mosi = mosi_w[c][pos];
          wait_clk(HALF);
          sck = ~p; b = miso;
          wait_clk(HALF);
          sck = p;
        end else begin
          sck = ~p; mosi = mosi_w[c][pos];
          wait_clk(HALF);
          sck = p; b = miso;
          wait_clk(HALF);
        end
        miso_w[c][pos] = b;
        seq = {seq[14:0], b};
        sent++;
      end
    end
    wait_clk(HALF);
    if (raise_cs) begin
      cs_n = 1'b1;
      wait_clk(10);
    end
  endtask

  task automatic test_reset();
    wait_clk(3);
    checks++;
    if ({miso, miso_oe, wready, rchar, rvalid} !== {1'b0, 1'b0, 1'b1, 16'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: got miso=%0b oe=%0b wready=%0b rchar=%h rvalid=%0b, required 0 0 1 0000 0",
               miso, miso_oe, wready, rchar, rvalid);
    end
    rst_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_mode0_basic();
    int n0 = rx_q.size();
    int h0 = rv_high;
    write_hold(16'h00A5);
    mosi_w[0] = 16'h003C;
    session(1'b0, 1'b0, 1'b1, 7, 1, -1, 1'b1);
    checks++;
    if (seq[7:0] !== 8'hA5) begin
      failures++; $display("FAIL mode0_miso_sequence: got %h, required a5", seq[7:0]);
    end
    checks++;
    if (rx_q.size() !== n0 + 1 || rx_q[$] !== 16'h003C) begin
      failures++; $display("FAIL mode0_rchar: got n=%0d last=%h, required n=%0d last=003c", rx_q.size() - n0, rx_q[$], 1);
    end
    checks++;
    if (rv_high - h0 !== 1) begin
      failures++; $display("FAIL mode0_valid_pulse: got %0d cycles, required 1", rv_high - h0);
    end
    checks++;
    if (miso_oe !== 1'b0) begin
      failures++; $display("FAIL mode0_oe_after: got %0b, required 0", miso_oe);
    end
  endtask

  task automatic test_modes();
    for (int m = 1; m <= 3; m++) begin
      write_hold(16'h1234);
      mosi_w[0] = 16'hBEEF;
      session(m >= 2, (m == 1) || (m == 3), 1'b0, 15, 1, -1, 1'b1);
      checks++;
      if (rx_q[$] !== 16'hBEEF) begin
        failures++; $display("FAIL mode%0d_rchar: got %h, required beef", m, rx_q[$]);
      end
      checks++;
      if (miso_w[0] !== 16'h1234) begin
        failures++; $display("FAIL mode%0d_miso: got %h, required 1234", m, miso_w[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] hw [3];
    int   n0 = rx_q.size();
    int   e0 = rv_events;
    logic p = 1'($urandom_range(0, 1));
    logic h = 1'($urandom_range(0, 1));
    logic r = 1'($urandom_range(0, 1));
    for (int k = 0; k < 3; k++) begin
      hw[k] = 16'($urandom_range(0, 255));
      mosi_w[k] = 16'($urandom_range(0, 255));
    end
    write_hold(hw[0]);
    fork
      session(p, h, r, 7, 3, -1, 1'b1);
      begin
        write_hold(hw[1]);
        write_hold(hw[2]);
      end
    join
    checks++;
    if (rv_events - e0 !== 3 || rx_q.size() - n0 !== 3) begin
      failures++; $display("FAIL b2b_count: got events=%0d consumed=%0d, required 3", rv_events - e0, rx_q.size() - n0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rx_q[n0 + k] !== mosi_w[k] || miso_w[k] !== hw[k]) begin
          failures++;
          $display("FAIL b2b_char%0d: got rx=%h miso=%h, required rx=%h miso=%h", k, rx_q[n0 + k], miso_w[k], mosi_w[k], hw[k]);
        end
      end
    end
  endtask

  task automatic test_abort();
    int n0 = rx_q.size();
    int e0 = rv_events;
    write_hold(16'h005A);
    mosi_w[0] = 16'($urandom_range(0, 255));
    session(1'b0, 1'b0, 1'b1, 7, 1, 5, 1'b1);
    checks++;
    if (rx_q.size() !== n0 || rv_events !== e0) begin
      failures++; $display("FAIL abort_no_valid: got events=%0d, required 0", rv_events - e0);
    end
    checks++;
    if (miso_oe !== 1'b0) begin
      failures++; $display("FAIL abort_oe: got %0b, required 0", miso_oe);
    end
    write_hold(16'h0042);
    mosi_w[0] = 16'h0081;
    session(1'b0, 1'b0, 1'b1, 7, 1, -1, 1'b1);
    checks++;
    if (rx_q[$] !== 16'h0081 || miso_w[0] !== 16'h0042) begin
      failures++; $display("FAIL abort_next_char: got rx=%h miso=%h, required rx=0081 miso=0042", rx_q[$], miso_w[0]);
    end
  endtask

  task automatic test_underrun();
    checks++;
    if (wready !== 1'b1) begin
      failures++; $display("FAIL underrun_hold_empty: wready=%0b, required 1", wready);
    end
`ifdef SPI_SLAVE_ERR_EN
    err_clr = 1'b1; wait_clk(1); err_clr = 1'b0; wait_clk(1);
    checks++;
    if (underrun !== 1'b0) begin
      failures++; $display("FAIL underrun_cleared_before: got %0b, required 0", underrun);
    end
`endif
    mosi_w[0] = 16'h0033;
    session(1'b0, 1'b0, 1'b1, 7, 1, -1, 1'b1);
    checks++;
    if (miso_w[0] !== 16'h00FF || rx_q[$] !== 16'h0033) begin
      failures++; $display("FAIL underrun_data: got miso=%h rx=%h, required miso=00ff rx=0033", miso_w[0], rx_q[$]);
    end
`ifdef SPI_SLAVE_ERR_EN
    checks++;
    if (underrun !== 1'b1) begin
      failures++; $display("FAIL underrun_flag: got %0b, required 1", underrun);
    end
    err_clr = 1'b1; wait_clk(1); err_clr = 1'b0; wait_clk(1);
    checks++;
    if (underrun !== 1'b0) begin
      failures++; $display("FAIL underrun_clear: got %0b, required 0", underrun);
    end
`endif
  endtask

  task automatic test_overrun();
    rready = 1'b0;
`ifdef SPI_SLAVE_ERR_EN
    err_clr = 1'b1; wait_clk(1); err_clr = 1'b0; wait_clk(1);
`endif
    mosi_w[0] = 16'h0011;
    session(1'b0, 1'b0, 1'b1, 7, 1, -1, 1'b1);
    mosi_w[0] = 16'h00E7;
    session(1'b0, 1'b0, 1'b1, 7, 1, -1, 1'b1);
    checks++;
    if (rchar !== 16'h00E7 || rvalid !== 1'b1) begin
      failures++; $display("FAIL overrun_rchar: got rchar=%h valid=%0b, required 00e7 1", rchar, rvalid);
    end
`ifdef SPI_SLAVE_ERR_EN
    checks++;
    if (overrun !== 1'b1) begin
      failures++; $display("FAIL overrun_flag: got %0b, required 1", overrun);
    end
`endif
    rready = 1'b1;
    wait_clk(2);
    checks++;
    if (rvalid !== 1'b0) begin
      failures++; $display("FAIL overrun_consume: got valid=%0b, required 0", rvalid);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int          len = $urandom_range(3, 15);
      int          n0 = rx_q.size();
      logic        fill = ($urandom_range(0, 9) < 7);
      logic [15:0] hw = 16'($urandom);
      logic [15:0] exp_miso;
      mosi_w[0] = 16'($urandom) & mask(len);
      if (fill) write_hold(hw);
      exp_miso = (fill ? hw : 16'hFFFF) & mask(len);
      session(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), len, 1, -1, 1'b1);
      checks++;
      if (rx_q.size() !== n0 + 1 || rx_q[$] !== mosi_w[0] || miso_w[0] !== exp_miso) begin
        failures++;
        $display("FAIL random%0d: got rx=%h miso=%h n=%0d, required rx=%h miso=%h n=1",
                 it, rx_q[$], miso_w[0], rx_q.size() - n0, mosi_w[0], exp_miso);
      end
    end
  endtask

  task automatic test_disable();
    int e0 = rv_events;
    enable = 1'b0;
    mosi_w[0] = 16'h00C3;
    session(1'b0, 1'b0, 1'b1, 7, 1, 4, 1'b0);
    checks++;
    if (miso_oe !== 1'b0) begin
      failures++; $display("FAIL disable_oe: got %0b, required 0", miso_oe);
    end
    cs_n = 1'b1; wait_clk(10);
    checks++;
    if (rv_events !== e0) begin
      failures++; $display("FAIL disable_no_rx: got %0d events, required 0", rv_events - e0);
    end
    enable = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_reset_midchar();
    write_hold(16'h0077);
    mosi_w[0] = 16'h00F0;
    session(1'b0, 1'b0, 1'b1, 7, 1, 3, 1'b0);
    write_hold(16'h0055);
    checks++;
    if (miso_oe !== 1'b1 || wready !== 1'b0) begin
      failures++; $display("FAIL midchar_active: got oe=%0b wready=%0b, required 1 0", miso_oe, wready);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({miso, miso_oe, wready, rchar, rvalid} !== {1'b0, 1'b0, 1'b1, 16'h0, 1'b0}) begin
      failures++;
      $display("FAIL midchar_reset: got miso=%0b oe=%0b wready=%0b rchar=%h rvalid=%0b, required 0 0 1 0000 0",
               miso, miso_oe, wready, rchar, rvalid);
    end
    cs_n = 1'b1; sck = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 1'b1; cpol = 1'b0; cpha = 1'b0; rev = 1'b1; char_len = 4'd7;
    sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    wchar = '0; wvalid = 1'b0; rready = 1'b1;
`ifdef SPI_SLAVE_ERR_EN
    err_clr = 1'b0;
`endif
    test_reset();
    test_mode0_basic();
    test_modes();
    test_back_to_back();
    test_abort();
    test_underrun();
    test_overrun();
    test_random();
    test_disable();
    test_reset_midchar();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
